bin2bcd_seq_conv: RTL and testbench

- Sequential signed binary-to-BCD converter (shift-and-add-3, one bit per clock).
- Parametrised in input width and output digit count.
- Sits between the core's register-observe outputs (RegisterContent / RegData) and LCD_Controller, replacing the fixed 2-digit comparator chain.
- Handles full 32-bit values, reports sign and overflow, and uses a start/busy/done handshake.

---
 rtl/bin2bcd_pkg.sv | 21 ++
 rtl/bin2bcd_seq_conv_digit_adj.sv | 10 +
 rtl/bin2bcd_seq_conv.sv | 162 ++++++++++++++++
 tb/tb_bin2bcd_seq_conv.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, the LCD blank code and a digit-count helper.
package bin2bcd_pkg;

  // Converter FSM states (IDLE -> SHIFT -> FINISH -> IDLE).
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Nibble code LCD_Controller renders as an empty character.
  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Smallest number of decimal digits that holds any width-bit unsigned
  // value: ceil(width * log10(2)), with log10(2) approximated as 0.30103.
  function automatic int min_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_conv_digit_adj.sv
// One BCD digit of the shift-and-add-3 datapath: a digit of 5 or more is
// bumped by 3 so that the following left shift carries into the next digit.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bin2bcd_seq_conv.sv
// Sequential signed binary-to-BCD converter, one magnitude bit per clock.
// Optional build macro: BIN2BCD_LEADING_BLANK_EN -- when defined, digits
// above the most significant non-zero digit are reported as the blank
// code instead of 0 (digit 0 is never blanked, overflow is never blanked).
module bin2bcd_seq_conv
  import bin2bcd_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DIGITS = 10,
  localparam int SIG_W  = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [DATA_W-1:0]     data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [SIG_W-1:0]      sig_digits
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  // Flat state constants so the register stays a plain vector.
  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SHIFT  = SHIFT;
  localparam logic [1:0] ST_FINISH = FINISH;

  // When DIGITS already covers every DATA_W-bit magnitude, a carry out of
  // the top digit is impossible and the overflow tracker folds away.
  localparam bit CAN_OVERFLOW = (DIGITS < min_digits(DATA_W));

`ifdef BIN2BCD_LEADING_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  // Code substituted for leading zero digits. Without blanking it is 0,
  // which leaves those digits unchanged.
  localparam logic [3:0] LEAD_CODE = BLANK_EN ? BCD_BLANK : 4'h0;

  logic [1:0]        state;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] mag;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_adj;
  logic              neg;
  logic              ovf_trk;

  logic              neg_in;
  logic [DATA_W-1:0] mag_in;
  logic              carry_out;
  logic [SIG_W-1:0]  sig_calc;
  logic [DIGITS-1:0] lead;
  logic [ACC_W-1:0]  bcd_fin;

  // Two's complement magnitude of the request. The most negative value
  // negates to itself, which read as unsigned is exactly 2^(DATA_W-1).
  assign neg_in = signed_mode & data_in[DATA_W-1];
  assign mag_in = neg_in ? ((~data_in) + DATA_W'(1)) : data_in;

  // Add-3 correction for every digit of the accumulator.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (acc[4*gi +: 4]),
      .adjusted (acc_adj[4*gi +: 4])
    );
  end

  // Bit leaving the top digit on this shift: the value no longer fits.
  assign carry_out = CAN_OVERFLOW & acc_adj[ACC_W-1];

  // Position of the highest non-zero digit plus one; a zero value reads 1.
  always_comb begin
    sig_calc = SIG_W'(1);
    for (int i = 1; i < DIGITS; i++) begin
      if (acc[4*i +: 4] != 4'd0) begin
        sig_calc = SIG_W'(i + 1);
      end
    end
  end

  // Final digit values: saturate on overflow, otherwise substitute the
  // lead code above the significant digits.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_fin
    assign lead[gi] = (gi != 0) && (gi >= int'(sig_calc));
    assign bcd_fin[4*gi +: 4] = ovf_trk  ? 4'd9      :
                                lead[gi] ? LEAD_CODE :
                                           acc[4*gi +: 4];
  end

  // Conversion FSM and the shift-and-add-3 datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      count   <= '0;
      mag     <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      ovf_trk <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            neg     <= neg_in;
            mag     <= mag_in;
            acc     <= '0;
            ovf_trk <= 1'b0;
            count   <= CNT_W'(DATA_W);
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc     <= {acc_adj[ACC_W-2:0], mag[DATA_W-1]};
          mag     <= {mag[DATA_W-2:0], 1'b0};
          ovf_trk <= ovf_trk | carry_out;
          count   <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake and result registers; results only change in FINISH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      sign       <= 1'b0;
      bcd        <= '0;
      overflow   <= 1'b0;
      sig_digits <= SIG_W'(1);
    end else begin
      done <= 1'b0;
      if ((state == ST_IDLE) && start) begin
        busy <= 1'b1;
      end
      if (state == ST_FINISH) begin
        busy       <= 1'b0;
        done       <= 1'b1;
        sign       <= neg;
        bcd        <= bcd_fin;
        overflow   <= ovf_trk;
        sig_digits <= ovf_trk ? SIG_W'(DIGITS) : sig_calc;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq_conv.sv
// Scoreboard bench for bin2bcd_seq_conv: a wide instance (32 bits, 10
// digits) and a narrow one (8 bits, 2 digits) that overflows readily.
module tb_bin2bcd_seq_conv;

  localparam int W1 = 32;
  localparam int D1 = 10;
  localparam int W2 = 8;
  localparam int D2 = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        start1, sm1;
  logic [31:0] din1;
  logic        busy1, done1, sign1, ovf1;
  logic [39:0] bcd1;
  logic [3:0]  sig1;

  logic        start2, sm2;
  logic [7:0]  din2;
  logic        busy2, done2, sign2, ovf2;
  logic [7:0]  bcd2;
  logic [1:0]  sig2;

  bin2bcd_seq_conv #(.DATA_W(W1), .DIGITS(D1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .signed_mode(sm1),
    .data_in(din1), .busy(busy1), .done(done1), .sign(sign1),
    .bcd(bcd1), .overflow(ovf1), .sig_digits(sig1)
  );

  bin2bcd_seq_conv #(.DATA_W(W2), .DIGITS(D2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .signed_mode(sm2),
    .data_in(din2), .busy(busy2), .done(done2), .sign(sign2),
    .bcd(bcd2), .overflow(ovf2), .sig_digits(sig2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          sgn;
    logic [39:0] bcd;
    bit          ovf;
    int          sig;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t m1, m2;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Decimal reference: magnitude by plain arithmetic, digits by div/mod.
  function automatic exp_t model(input logic [31:0] d, input int w, input bit sm, input int nd);
    exp_t e;
    longint unsigned v, lim, t;
    int n;
    v = 0;
    for (int i = 0; i < w; i++) v[i] = d[i];
    e.sgn = sm && d[w-1];
    if (e.sgn) v = (64'd1 << w) - v;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    e.bcd = '0;
    e.ovf = 1'b0;
    e.due = 0;
    if (v >= lim) begin
      e.ovf = 1'b1;
      e.sig = nd;
      for (int i = 0; i < nd; i++) e.bcd[4*i +: 4] = 4'd9;
    end else begin
      n = 0;
      t = v;
      do begin
        n++;
        t = t / 10;
      end while (t != 0);
      e.sig = n;
      t = v;
      for (int i = 0; i < nd; i++) begin
        e.bcd[4*i +: 4] = 4'(t % 10);
        t = t / 10;
`ifdef BIN2BCD_LEADING_BLANK_EN
        if (i >= n) e.bcd[4*i +: 4] = 4'hF;
`endif
      end
    end
    return e;
  endfunction

  // Monitor for the wide instance.
  always @(negedge clk) begin
    if (reset_n && done1) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL d1_spurious_done: actual done=1 required no pending conversion (cycle %0d)", cyc);
      end else begin
        m1 = q1.pop_front();
        $display("dut1 txn cycle %0d: bcd=%h sign=%0d ovf=%0d sig=%0d", cyc, bcd1, sign1, ovf1, sig1);
        check("d1_latency", 64'(cyc), 64'(m1.due));
        check("d1_bcd", 64'(bcd1), 64'(m1.bcd));
        check("d1_sign", 64'(sign1), 64'(m1.sgn));
        check("d1_overflow", 64'(ovf1), 64'(m1.ovf));
        check("d1_sig_digits", 64'(sig1), 64'(m1.sig));
        check("d1_busy_at_done", 64'(busy1), 64'd0);
      end
    end
  end

  // Monitor for the narrow instance.
  always @(negedge clk) begin
    if (reset_n && done2) begin
      if (q2.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL d2_spurious_done: actual done=1 required no pending conversion (cycle %0d)", cyc);
      end else begin
        m2 = q2.pop_front();
        $display("dut2 txn cycle %0d: bcd=%h sign=%0d ovf=%0d sig=%0d", cyc, bcd2, sign2, ovf2, sig2);
        check("d2_latency", 64'(cyc), 64'(m2.due));
        check("d2_bcd", 64'(bcd2), 64'(m2.bcd[7:0]));
        check("d2_sign", 64'(sign2), 64'(m2.sgn));
        check("d2_overflow", 64'(ovf2), 64'(m2.ovf));
        check("d2_sig_digits", 64'(sig2), 64'(m2.sig));
        check("d2_busy_at_done", 64'(busy2), 64'd0);
      end
    end
  end

  // Issue one conversion; called and returning at a negative edge.
  // With noise set, further start pulses with changing data are thrown at
  // the converter while it is busy; they must have no effect.
  task automatic issue(input int sel, input logic [31:0] d, input bit sm, input bit noise);
    int guard;
    exp_t e;
    guard = 0;
    while ((sel == 1 ? busy1 : busy2) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: actual busy=1 required busy=0 within 200 cycles (dut%0d)", sel);
      return;
    end
    if (sel == 1) begin
      e = model(d, W1, sm, D1);
      e.due = cyc + W1 + 2;
      q1.push_back(e);
      start1 = 1'b1; sm1 = sm; din1 = d;
    end else begin
      e = model(d, W2, sm, D2);
      e.due = cyc + W2 + 2;
      q2.push_back(e);
      start2 = 1'b1; sm2 = sm; din2 = d[7:0];
    end
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    if (noise) begin
      for (int i = 0; i < 60; i++) begin
        if (!(sel == 1 ? busy1 : busy2)) break;
        if (sel == 1) begin
          start1 = 1'($urandom_range(0, 1)); sm1 = 1'($urandom_range(0, 1)); din1 = $urandom;
        end else begin
          start2 = 1'($urandom_range(0, 1)); sm2 = 1'($urandom_range(0, 1)); din2 = 8'($urandom);
        end
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] pick_value();
    logic [31:0] edges [6];
    edges[0] = 32'h0000_0000; edges[1] = 32'h8000_0000; edges[2] = 32'hFFFF_FFFF;
    edges[3] = 32'h7FFF_FFFF; edges[4] = 32'd999_999_999; edges[5] = 32'd1_000_000_000;
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 999));
      2: return -32'($urandom_range(1, 999));
      default: return edges[$urandom_range(0, 5)];
    endcase
  endfunction

  initial begin
    int guard;
    start1 = 1'b0; sm1 = 1'b0; din1 = '0;
    start2 = 1'b0; sm2 = 1'b0; din2 = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_done", 64'(done1), 64'd0);
    check("rst_sign", 64'(sign1), 64'd0);
    check("rst_bcd", 64'(bcd1), 64'd0);
    check("rst_overflow", 64'(ovf1), 64'd0);
    check("rst_sig_digits", 64'(sig1), 64'd1);
    check("rst_sig_digits_d2", 64'(sig2), 64'd1);

    reset_n = 1'b1;
    @(negedge clk);

    // Directed cases on the wide instance.
    issue(1, 32'd57, 1'b1, 1'b1);
    issue(1, 32'hFFFF_FFC5, 1'b1, 1'b0);
    issue(1, 32'h8000_0000, 1'b1, 1'b1);
    issue(1, 32'h8000_0000, 1'b0, 1'b0);
    issue(1, 32'd0, 1'b1, 1'b0);
    issue(1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    issue(1, 32'h7FFF_FFFF, 1'b1, 1'b0);

    // Randomised cases on the wide instance.
    for (int i = 0; i < 30; i++) begin
      issue(1, pick_value(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a conversion: outputs drop at once, no done.
    issue(1, 32'd123_456, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    q1.delete();
    #1;
    check("midrst_busy", 64'(busy1), 64'd0);
    check("midrst_done", 64'(done1), 64'd0);
    check("midrst_bcd", 64'(bcd1), 64'd0);
    check("midrst_sig_digits", 64'(sig1), 64'd1);
    check("midrst_overflow", 64'(ovf1), 64'd0);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(1, 32'd4_000_000_000, 1'b0, 1'b0);
    issue(1, 32'hFFFF_FFC5, 1'b1, 1'b0);

    // Narrow instance: overflow saturation and recovery.
    issue(2, 32'd123, 1'b0, 1'b0);
    issue(2, 32'd0, 1'b0, 1'b0);
    issue(2, 32'd99, 1'b0, 1'b1);
    issue(2, 32'd100, 1'b0, 1'b0);
    issue(2, 32'h80, 1'b1, 1'b0);
    issue(2, 32'hF6, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      issue(2, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    guard = 0;
    while ((q1.size() != 0 || q2.size() != 0) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("drain_q1", 64'(q1.size()), 64'd0);
    check("drain_q2", 64'(q2.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
